// File: rtl/mips_multi_cycle.sv
// Multi-cycle MIPS core: shared datapath sequenced by a FETCH/DECODE/EXEC/MEM/WB FSM over one
// unified instruction/data memory.
//
// Ports:
//   clk, reset_n                    clock and asynchronous active-low reset
//   load_en, load_addr, load_data   bench-side memory write port, live even during reset
//   dbg_reg_sel, dbg_reg_data       combinational register-file peek (index 0 reads 0)
//   pc, instruction, state          architectural PC, IR, FSM state encoding
//   halted, retired                 halt flag, completed-instruction counter
module mips_multi_cycle #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MEM_DEPTH = 2 ** ADDR_W,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic [4:0]        dbg_reg_sel,
  output logic [31:0]       dbg_reg_data,
  output logic [31:0]       pc,
  output logic [31:0]       instruction,
  output logic [2:0]        state,
  output logic              halted,
  output logic [31:0]       retired
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] FnAdd   = 6'b100000;
  localparam logic [5:0] FnSub   = 6'b100010;
  localparam logic [5:0] FnAnd   = 6'b100100;
  localparam logic [5:0] FnOr    = 6'b100101;
  localparam logic [5:0] FnSlt   = 6'b101010;

  logic [31:0] mem [MEM_DEPTH];
  logic [31:0] rf_q [32];

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0] alu_q, alu_d, mdr_q, mdr_d, retired_q, retired_d;
  logic        halted_q;
  logic        rf_we, mem_we, legal;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, alu_r;

  logic [5:0]        opcode, funct;
  logic [4:0]        rs, rt, rd;
  logic [31:0]       sext_imm;
  logic [ADDR_W-1:0] pc_idx, alu_idx;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};
  // Byte address to word index; low two bits and bits above the index are dropped.
  assign pc_idx   = pc_q[ADDR_W+1:2];
  assign alu_idx  = alu_q[ADDR_W+1:2];

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OpRtype:                      legal = funct inside {FnAdd, FnSub, FnAnd, FnOr, FnSlt};
      OpAddi, OpLw, OpSw, OpBeq, OpJ: legal = 1'b1;
      default:                      legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_r = '0;
    case (funct)
      FnAdd:   alu_r = a_q + b_q;
      FnSub:   alu_r = a_q - b_q;
      FnAnd:   alu_r = a_q & b_q;
      FnOr:    alu_r = a_q | b_q;
      FnSlt:   alu_r = {31'b0, $signed(a_q) < $signed(b_q)};
      default: alu_r = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_d     = alu_q;
    mdr_d     = mdr_q;
    retired_d = retired_q;
    rf_we     = 1'b0;
    rf_waddr  = rt;
    rf_wdata  = alu_q;
    mem_we    = 1'b0;
    unique case (state_q)
      StFetch: begin
        ir_d    = mem[pc_idx];
        pc_d    = pc_q + 32'd4;
        state_d = StDecode;
      end
      StDecode: begin
        a_d     = rf_q[rs];
        b_d     = rf_q[rt];
        // Speculative branch target, using the already-incremented pc.
        alu_d   = pc_q + {sext_imm[29:0], 2'b00};
        state_d = legal ? StExec : StHalt;
      end
      StExec: begin
        case (opcode)
          OpRtype: begin
            alu_d   = alu_r;
            state_d = StWb;
          end
          OpAddi: begin
            alu_d   = a_q + sext_imm;
            state_d = StWb;
          end
          OpLw, OpSw: begin
            alu_d   = a_q + sext_imm;
            state_d = StMem;
          end
          OpBeq: begin
            if (a_q == b_q) pc_d = alu_q;
            state_d = StFetch;
          end
          OpJ: begin
            pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
            state_d = StFetch;
          end
          default: state_d = StHalt;
        endcase
      end
      StMem: begin
        if (opcode == OpLw) begin
          mdr_d   = mem[alu_idx];
          state_d = StWb;
        end else begin
          mem_we  = 1'b1;
          state_d = StFetch;
        end
      end
      StWb: begin
        rf_we = 1'b1;
        if (opcode == OpRtype) begin
          rf_waddr = rd;
        end else if (opcode == OpLw) begin
          rf_wdata = mdr_q;
        end
        state_d = StFetch;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StHalt;
    endcase
    if (state_d == StFetch && state_q inside {StExec, StMem, StWb}) begin
      retired_d = retired_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      retired_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_q     <= alu_d;
      mdr_q     <= mdr_d;
      retired_q <= retired_d;
      halted_q  <= (state_d == StHalt);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we && rf_waddr != 5'd0) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // No reset on memory. The load write is issued last so it wins a same-word collision with sw.
  always_ff @(posedge clk) begin
    if (mem_we)  mem[alu_idx]   <= b_q;
    if (load_en) mem[load_addr] <= load_data;
  end

  assign dbg_reg_data = (dbg_reg_sel == 5'd0) ? '0 : rf_q[dbg_reg_sel];
  assign pc           = pc_q;
  assign instruction  = ir_q;
  assign state        = state_q;
  assign halted       = halted_q;
  assign retired      = retired_q;

endmodule
